// File: rtl/shift_ram_pkg.sv
// Shared helpers for the dynamic shift RAM: pointer arithmetic, width helper and the output-select encoding.
package shift_ram_pkg;

   localparam int C_DEPTH_DFLT = 64;

   typedef enum logic [1:0] {
      SEL_INIT = 2'd0,
      SEL_BYP  = 2'd1,
      SEL_RAM  = 2'd2
   } q_sel_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = 1; v < n; v = v * 2) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Modulo subtraction that never assumes a power-of-two depth.
   function automatic int wrap_sub(input int ptr, input int off, input int depth);
      return (ptr >= off) ? (ptr - off) : (ptr + depth - off);
   endfunction

   localparam int FILL_W_DFLT = clog2(C_DEPTH_DFLT + 1);

endpackage

// File: rtl/shift_ram_sdp_mem.sv
// Simple dual-port RAM: one write port, one registered read port gated by re; no reset so it maps to BRAM/LUTRAM.
module shift_ram_sdp_mem
   import shift_ram_pkg::*;
#(
   parameter int C_WIDTH      = 16,
   parameter int C_DEPTH      = C_DEPTH_DFLT,
   parameter int C_ADDR_WIDTH = 6
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [C_ADDR_WIDTH-1:0] waddr,
   input  logic [C_WIDTH-1:0]      wdat,
   input  logic                    re,
   input  logic [C_ADDR_WIDTH-1:0] raddr,
   output logic [C_WIDTH-1:0]      rdat
);

   logic [C_WIDTH-1:0] mem [C_DEPTH];
   logic [C_WIDTH-1:0] rdat_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdat;
      end
      if (re) begin
         rdat_q <= mem[raddr];
      end
   end

   assign rdat = rdat_q;

endmodule

// File: rtl/shift_ram_dyn_v5.sv
// Runtime-programmable RAM delay line: Q lags D by A+1 CE edges (A+2 when SHIFT_RAM_PIPE_READ_EN is defined).
// All state holds while CE=0; ACLR/SINIT restart priming (Q_VALID low) without clearing the RAM.
module shift_ram_dyn_v5
   import shift_ram_pkg::*;
#(
   parameter int                 C_WIDTH      = 16,
   parameter int                 C_DEPTH      = C_DEPTH_DFLT,
   parameter int                 C_ADDR_WIDTH = 6,
   parameter logic [C_WIDTH-1:0] C_AINIT_VAL  = '0
) (
   input  logic                    CLK,
   input  logic                    ACLR,
   input  logic                    CE,
   input  logic                    SINIT,
   input  logic [C_ADDR_WIDTH-1:0] A,
   input  logic [C_WIDTH-1:0]      D,
   output logic [C_WIDTH-1:0]      Q,
   output logic                    Q_VALID,
   output logic                    ERR
);

   localparam int                      FILL_W   = clog2(C_DEPTH + 1);
   localparam logic [C_ADDR_WIDTH-1:0] PTR_LAST = C_ADDR_WIDTH'(C_DEPTH - 1);
   localparam logic [FILL_W-1:0]       FILL_MAX = FILL_W'(C_DEPTH);

   logic [C_ADDR_WIDTH-1:0] wp_q, wp_d;
   logic [C_ADDR_WIDTH-1:0] a_q, a_d;
   logic [FILL_W-1:0]       fill_q, fill_d;
   logic                    err_q, err_d;
   logic                    vld_q, vld_d;
   q_sel_e                  sel_q, sel_d;
   logic [C_WIDTH-1:0]      byp_q, byp_d;

   logic                    a_oor;
   logic [C_ADDR_WIDTH-1:0] a_eff;
   logic [C_ADDR_WIDTH-1:0] rd_addr;
   logic                    ram_en;
   logic [C_WIDTH-1:0]      ram_rdat;
   logic [C_WIDTH-1:0]      q_mux;

   assign a_oor   = (32'(A) >= 32'(C_DEPTH));
   assign a_eff   = a_oor ? PTR_LAST : A;
   assign rd_addr = C_ADDR_WIDTH'(wrap_sub(int'(wp_q), int'(a_eff), C_DEPTH));
   assign ram_en  = CE & ~SINIT;

   shift_ram_sdp_mem #(
      .C_WIDTH      (C_WIDTH),
      .C_DEPTH      (C_DEPTH),
      .C_ADDR_WIDTH (C_ADDR_WIDTH)
   ) u_mem (
      .clk   (CLK),
      .we    (ram_en),
      .waddr (wp_q),
      .wdat  (D),
      .re    (ram_en),
      .raddr (rd_addr),
      .rdat  (ram_rdat)
   );

   always_comb begin
      wp_d   = wp_q;
      a_d    = a_q;
      fill_d = fill_q;
      err_d  = err_q;
      vld_d  = vld_q;
      sel_d  = sel_q;
      byp_d  = byp_q;
      if (SINIT) begin
         wp_d   = '0;
         a_d    = '0;
         fill_d = '0;
         err_d  = 1'b0;
         vld_d  = 1'b0;
         sel_d  = SEL_INIT;
      end else if (CE) begin
         wp_d  = (wp_q == PTR_LAST) ? '0 : wp_q + C_ADDR_WIDTH'(1);
         a_d   = a_eff;
         err_d = err_q | a_oor;
         byp_d = D;
         sel_d = (a_eff == '0) ? SEL_BYP : SEL_RAM;
         // A new delay invalidates what is buffered: only this edge's sample counts as stored.
         if (a_eff != a_q) begin
            fill_d = FILL_W'(1);
            vld_d  = (a_eff == '0);
         end else begin
            fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
            vld_d  = (32'(fill_q) >= 32'(a_eff));
         end
      end
   end

   always_ff @(posedge CLK or posedge ACLR) begin
      if (ACLR) begin
         wp_q   <= '0;
         a_q    <= '0;
         fill_q <= '0;
         err_q  <= 1'b0;
         vld_q  <= 1'b0;
         sel_q  <= SEL_INIT;
         byp_q  <= C_AINIT_VAL;
      end else begin
         wp_q   <= wp_d;
         a_q    <= a_d;
         fill_q <= fill_d;
         err_q  <= err_d;
         vld_q  <= vld_d;
         sel_q  <= sel_d;
         byp_q  <= byp_d;
      end
   end

   // The RAM read register has no reset, so the init value is selected in front of it.
   always_comb begin
      q_mux = ram_rdat;
      case (sel_q)
         SEL_INIT: q_mux = C_AINIT_VAL;
         SEL_BYP:  q_mux = byp_q;
         default:  q_mux = ram_rdat;
      endcase
   end

`ifdef SHIFT_RAM_PIPE_READ_EN
   logic [C_WIDTH-1:0] q_pipe_q, q_pipe_d;
   logic               vld_pipe_q, vld_pipe_d;

   always_comb begin
      q_pipe_d   = q_pipe_q;
      vld_pipe_d = vld_pipe_q;
      if (SINIT) begin
         q_pipe_d   = C_AINIT_VAL;
         vld_pipe_d = 1'b0;
      end else if (CE) begin
         q_pipe_d   = q_mux;
         vld_pipe_d = vld_q;
      end
   end

   always_ff @(posedge CLK or posedge ACLR) begin
      if (ACLR) begin
         q_pipe_q   <= C_AINIT_VAL;
         vld_pipe_q <= 1'b0;
      end else begin
         q_pipe_q   <= q_pipe_d;
         vld_pipe_q <= vld_pipe_d;
      end
   end

   assign Q       = q_pipe_q;
   assign Q_VALID = vld_pipe_q;
`else
   assign Q       = q_mux;
   assign Q_VALID = vld_q;
`endif

   assign ERR = err_q;

endmodule

// File: tb/tb_shift_ram_dyn_v5.sv
// Directed + randomized bench for shift_ram_dyn_v5 against a history-queue reference model.
module tb_shift_ram_dyn_v5;

   localparam int W     = 16;
   localparam int DEPTH = 48;
   localparam int AW    = 6;
   localparam logic [W-1:0] AINIT = 16'hA5A5;
`ifdef SHIFT_RAM_PIPE_READ_EN
   localparam int PIPE = 1;
`else
   localparam int PIPE = 0;
`endif

   logic          clk = 1'b0;
   logic          aclr;
   logic          ce;
   logic          sinit;
   logic [AW-1:0] a;
   logic [W-1:0]  d;
   logic [W-1:0]  q;
   logic          q_valid;
   logic          err;

   int checks = 0;
   int errors = 0;

   // Reference model: samples written since last init, edges since init/delay change.
   logic [W-1:0] hist[$];
   int           run;
   int           prev_a;
   logic         m_err;
   logic [W-1:0] s1_q, out_q;
   logic         s1_v, out_v;

   always #5 clk = ~clk;

   shift_ram_dyn_v5 #(
      .C_WIDTH      (W),
      .C_DEPTH      (DEPTH),
      .C_ADDR_WIDTH (AW),
      .C_AINIT_VAL  (AINIT)
   ) dut (
      .CLK     (clk),
      .ACLR    (aclr),
      .CE      (ce),
      .SINIT   (sinit),
      .A       (a),
      .D       (d),
      .Q       (q),
      .Q_VALID (q_valid),
      .ERR     (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic m_init();
      hist.delete();
      run    = 0;
      prev_a = 0;
      m_err  = 1'b0;
      s1_q   = AINIT;
      s1_v   = 1'b0;
      out_q  = AINIT;
      out_v  = 1'b0;
   endtask

   task automatic m_ce(input int a_in, input logic [W-1:0] din);
      int           ae;
      int           n;
      logic [W-1:0] nq;
      logic         nv;
      ae = (a_in >= DEPTH) ? DEPTH - 1 : a_in;
      if (a_in >= DEPTH) m_err = 1'b1;
      hist.push_back(din);
      n = hist.size() - 1;
      if (ae != prev_a) begin
         nv  = (ae == 0);
         run = 1;
      end else begin
         nv  = (run >= ae);
         run = run + 1;
      end
      prev_a = ae;
      nq = (n >= ae) ? hist[n - ae] : 'x;
      if (PIPE != 0) begin
         out_q = s1_q;
         out_v = s1_v;
         s1_q  = nq;
         s1_v  = nv;
      end else begin
         out_q = nq;
         out_v = nv;
      end
   endtask

   task automatic cycle(input logic c, input logic s, input int a_in, input logic [W-1:0] din);
      ce    = c;
      sinit = s;
      a     = AW'(a_in);
      d     = din;
      @(posedge clk);
      if (s) m_init();
      else if (c) m_ce(a_in, din);
      #1;
      check("q_valid", 32'(q_valid), 32'(out_v));
      check("err", 32'(err), 32'(m_err));
      if (out_v) check("q", 32'(q), 32'(out_q));
   endtask

   initial begin
      int lows;
      int cur_a;
      aclr  = 1'b1;
      ce    = 1'b0;
      sinit = 1'b0;
      a     = '0;
      d     = '0;
      m_init();
      #12;
      check("rst_q", 32'(q), 32'(AINIT));
      check("rst_valid", 32'(q_valid), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      aclr = 1'b0;

      // 1: A=9 ramp, valid rises after edge 10, first valid sample is 1
      for (int i = 1; i <= 30; i++) begin
         cycle(1'b1, 1'b0, 9, W'(i));
         check("t1_valid_edge", 32'(q_valid), 32'(i >= 10 + PIPE));
         if (i == 10 + PIPE) check("t1_first_q", 32'(q), 32'd1);
      end

      // 2: A=0 bypass
      cycle(1'b0, 1'b1, 0, '0);
      check("t2_sinit_q", 32'(q), 32'(AINIT));
      for (int i = 1; i <= 10; i++) begin
         cycle(1'b1, 1'b0, 0, W'(16'h200 + i));
         check("t2_valid_edge", 32'(q_valid), 32'(i >= 1 + PIPE));
      end

      // 3: full depth across pointer wrap, then out-of-range A clamps
      cycle(1'b0, 1'b1, 0, '0);
      for (int i = 1; i <= 200; i++) cycle(1'b1, 1'b0, 47, W'(i));
      for (int i = 201; i <= 220; i++) cycle(1'b1, 1'b0, 50, W'(i));
      check("t3_err", 32'(err), 32'd1);
      check("t3_valid_clamped", 32'(q_valid), 32'd1);
      check("t3_q_clamped", 32'(q), 32'(220 - 47 - PIPE));

      // 4: delay change 5 -> 2 drops valid for exactly 2 edges
      cycle(1'b0, 1'b1, 0, '0);
      for (int i = 1; i <= 20; i++) cycle(1'b1, 1'b0, 5, W'(16'h400 + i));
      lows = 0;
      for (int i = 1; i <= 10; i++) begin
         cycle(1'b1, 1'b0, 2, W'(16'h500 + i));
         if (!q_valid) lows++;
      end
      check("t4_low_edges", 32'(lows), 32'd2);

      // 5: random CE, random data, occasional random delay (incl. out of range)
      cycle(1'b0, 1'b1, 0, '0);
      cur_a = 7;
      for (int i = 0; i < 400; i++) begin
         if (i % 80 == 79) cur_a = int'($urandom_range(0, 55));
         cycle(1'($urandom_range(0, 1)), 1'b0, cur_a, W'($urandom));
      end

      // 6: ACLR pulse mid-stream, then reprime
      cycle(1'b0, 1'b1, 0, '0);
      for (int i = 1; i <= 12; i++) cycle(1'b1, 1'b0, 60, W'(16'h600 + i));
      #2;
      aclr = 1'b1;
      #1;
      check("t6_aclr_q", 32'(q), 32'(AINIT));
      check("t6_aclr_valid", 32'(q_valid), 32'd0);
      check("t6_aclr_err", 32'(err), 32'd0);
      m_init();
      #1;
      aclr = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         cycle(1'b1, 1'b0, 9, W'(16'h700 + i));
         check("t6_reprime_valid", 32'(q_valid), 32'(i >= 10 + PIPE));
      end

      // SINIT with CE: init wins, D not stored
      cycle(1'b1, 1'b1, 9, 16'hBEEF);
      check("t6_sinit_q", 32'(q), 32'(AINIT));
      check("t6_sinit_valid", 32'(q_valid), 32'd0);
      for (int i = 1; i <= 15; i++) begin
         cycle(1'b1, 1'b0, 9, W'(16'h100 + i));
         if (i == 10 + PIPE) check("t6_sinit_first_q", 32'(q), 32'h101);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
